// File: rtl/disp_sched_rec_pkg.sv
// Shared types and helpers for the display-control schedule recorder:
// serialiser state encoding, BCD digit type and per-digit increment.
package disp_sched_rec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    VAL  = 2'd1,
    TIME = 2'd2
  } sched_state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam int DROP_W = 16;

  // Returns {carry_out, next_digit}; a digit at 9 with carry-in rolls to 0.
  function automatic logic [4:0] bcd_digit_inc(input bcd_digit_t d, input logic cin);
    logic [4:0] r;
    if (!cin) begin
      r = {1'b0, d};
    end else if (d >= 4'd9) begin
      r = {1'b1, 4'd0};
    end else begin
      r = {1'b0, d + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/disp_rec_fifo.sv
// Synchronous FIFO holding {value, timestamp} entries; a push while full
// is accepted when a pop happens on the same edge.
module disp_rec_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/disp_sched_recorder.sv
// Records changes of a display-control vector with BCD cycle timestamps and
// streams them as value/time word pairs. DISP_SCHED_REC_MASK_EN adds DispMask.
module disp_sched_recorder
  import disp_sched_rec_pkg::*;
#(
  parameter int DISP_BITS  = 32,
  parameter int TIME_DIGS  = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     Clk,
  input  logic                     nReset,
  input  logic [DISP_BITS-1:0]     DispIn,
`ifdef DISP_SCHED_REC_MASK_EN
  input  logic [DISP_BITS-1:0]     DispMask,
`endif
  input  logic                     Flush,
  output logic [TIME_DIGS*4-1:0]   WordOut,
  output logic                     WordValid,
  input  logic                     WordReady,
  output logic                     WordIsTime,
  output logic                     Overflow,
  output logic [DROP_W-1:0]        DropCount,
  output logic                     Done,
  output logic [1:0]               DbgState
);

  localparam int W  = TIME_DIGS * 4;
  localparam int FW = DISP_BITS + W;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DROP_W-1:0] DROP_ONE = 1;

  sched_state_e          state_q, state_d;
  logic [DISP_BITS-1:0]  prev_q, cur_val;
  logic [W-1:0]          cnt_q, cnt_d;
  logic                  flush_q, done_q, ovf_q;
  logic [DROP_W-1:0]     drops_q;
  logic                  change, pop, drop;
  logic                  fifo_full, fifo_empty;
  logic [FW-1:0]         fifo_rdata;
  logic [CW-1:0]         fifo_count;

`ifdef DISP_SCHED_REC_MASK_EN
  assign cur_val = DispIn & DispMask;
`else
  assign cur_val = DispIn;
`endif

  assign change = !flush_q && (cur_val != prev_q);
  assign pop    = (state_q == TIME) && WordReady;
  assign drop   = change && fifo_full && !pop;

  disp_rec_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (Clk),
    .rst_ni  (nReset),
    .push_i  (change),
    .data_i  ({cur_val, cnt_q}),
    .pop_i   (pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    logic       carry;
    logic [4:0] step;
    cnt_d = cnt_q;
    carry = 1'b1;
    step  = '0;
    for (int i = 0; i < TIME_DIGS; i++) begin
      step             = bcd_digit_inc(cnt_q[i*4 +: 4], carry);
      cnt_d[i*4 +: 4]  = step[3:0];
      carry            = step[4];
    end
  end

  // In TIME a pop always accepts a same-edge push, so a change keeps us busy.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!fifo_empty) state_d = VAL;
      VAL:     if (WordReady)   state_d = TIME;
      TIME:    if (WordReady)   state_d = ((fifo_count > CW'(1)) || change) ? VAL : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    WordOut = '0;
    if (state_q == VAL) begin
      WordOut[DISP_BITS-1:0] = fifo_rdata[FW-1 -: DISP_BITS];
    end else if (state_q == TIME) begin
      WordOut = fifo_rdata[W-1:0];
    end
  end

  assign WordValid  = (state_q != IDLE);
  assign WordIsTime = (state_q == TIME);
  assign Overflow   = ovf_q;
  assign DropCount  = drops_q;
  assign Done       = done_q;
  assign DbgState   = state_q;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      prev_q  <= '0;
      cnt_q   <= '0;
      flush_q <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      drops_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (change) prev_q <= cur_val;
      if (Flush) flush_q <= 1'b1;
      if (flush_q && (state_q == IDLE) && fifo_empty) done_q <= 1'b1;
      if (drop) begin
        ovf_q <= 1'b1;
        if (drops_q != '1) drops_q <= drops_q + DROP_ONE;
      end
    end
  end

endmodule

// File: tb/tb_disp_sched_recorder.sv
// Randomised and directed bench for disp_sched_recorder against a
// queue-based reference of the recorded schedule.
module tb_disp_sched_recorder;

  localparam int DB    = 32;
  localparam int TD    = 16;
  localparam int W     = TD * 4;
  localparam int DEPTH = 8;

  // ---------------- clock / reset ----------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [DB-1:0] disp, mask;
  logic          flush, ready;
  logic [W-1:0]  word;
  logic          valid, is_time, ovf, done;
  logic [15:0]   drops;
  logic [1:0]    dbg;

  disp_sched_recorder #(.DISP_BITS(DB), .TIME_DIGS(TD), .FIFO_DEPTH(DEPTH)) dut (
    .Clk        (clk),
    .nReset     (rst_n),
    .DispIn     (disp),
`ifdef DISP_SCHED_REC_MASK_EN
    .DispMask   (mask),
`endif
    .Flush      (flush),
    .WordOut    (word),
    .WordValid  (valid),
    .WordReady  (ready),
    .WordIsTime (is_time),
    .Overflow   (ovf),
    .DropCount  (drops),
    .Done       (done),
    .DbgState   (dbg)
  );

  // Small instance for timestamp wrap: 2 BCD digits.
  logic       w_rst_n, w_flush, w_ready;
  logic [7:0] w_disp, w_mask, w_word;
  logic       w_valid, w_is_time, w_ovf, w_done;
  logic [15:0] w_drops;
  logic [1:0] w_dbg;
  logic [7:0] wlog[$];

  disp_sched_recorder #(.DISP_BITS(8), .TIME_DIGS(2), .FIFO_DEPTH(4)) dut_wrap (
    .Clk        (clk),
    .nReset     (w_rst_n),
    .DispIn     (w_disp),
`ifdef DISP_SCHED_REC_MASK_EN
    .DispMask   (w_mask),
`endif
    .Flush      (w_flush),
    .WordOut    (w_word),
    .WordValid  (w_valid),
    .WordReady  (w_ready),
    .WordIsTime (w_is_time),
    .Overflow   (w_ovf),
    .DropCount  (w_drops),
    .Done       (w_done),
    .DbgState   (w_dbg)
  );

  always @(posedge clk) begin
    if (w_rst_n && w_valid && w_ready) wlog.push_back(w_word);
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input longint unsigned v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < TD; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // ---------------- reference model (scoreboard) ----------------
  logic [W-1:0]    exp_val_q[$];
  logic [W-1:0]    exp_time_q[$];
  logic [W-1:0]    log_w[$];
  bit              log_t[$];
  longint unsigned m_cyc;
  logic [DB-1:0]   m_prev, m_cur;
  logic [W-1:0]    m_ext;
  bit              m_flushed, m_done, m_ovf, m_phase_time, m_done_cond;
  int              m_drops, m_size_prev, m_size_now;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_val_q.delete();
      exp_time_q.delete();
      log_w.delete();
      log_t.delete();
      m_cyc = 0;
      m_prev = '0;
      m_flushed = 0;
      m_done = 0;
      m_ovf = 0;
      m_phase_time = 0;
      m_drops = 0;
      m_size_prev = 0;
      m_size_now = 0;
    end else begin
      m_done_cond = m_flushed && (exp_val_q.size() == 0);
      if (valid && ready) begin
        log_w.push_back(word);
        log_t.push_back(is_time);
        if (m_phase_time) begin
          if (exp_val_q.size() > 0) begin
            void'(exp_val_q.pop_front());
            void'(exp_time_q.pop_front());
          end
          m_phase_time = 0;
        end else begin
          m_phase_time = 1;
        end
      end
      m_cur = disp & mask;
      if (!m_flushed && (m_cur != m_prev)) begin
        if (exp_val_q.size() < DEPTH) begin
          m_ext = '0;
          m_ext[DB-1:0] = m_cur;
          exp_val_q.push_back(m_ext);
          exp_time_q.push_back(to_bcd(m_cyc));
        end else begin
          m_ovf = 1;
          if (m_drops < 65535) m_drops++;
        end
        m_prev = m_cur;
      end
      if (flush) m_flushed = 1;
      if (m_done_cond) m_done = 1;
      m_cyc++;
      m_size_prev = m_size_now;
      m_size_now = exp_val_q.size();
    end
  end

  // A pair is on the bus once the FIFO has held it across one full edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check_eq("valid", 64'(valid), 64'((m_size_now > 0) && (m_size_prev > 0)));
      if (valid && (m_size_now > 0)) begin
        check_eq("is_time", 64'(is_time), 64'(m_phase_time));
        check_eq("word", word, m_phase_time ? exp_time_q[0] : exp_val_q[0]);
      end
      check_eq("overflow", 64'(ovf), 64'(m_ovf));
      check_eq("drop_count", 64'(drops), 64'(m_drops));
      check_eq("done", 64'(done), 64'(m_done));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input logic [DB-1:0] d0);
    @(negedge clk);
    rst_n = 1'b0;
    disp  = d0;
    flush = 1'b0;
    #1;
    check_eq("rst_valid", 64'(valid), 64'h0);
    check_eq("rst_word", word, 64'h0);
    check_eq("rst_is_time", 64'(is_time), 64'h0);
    check_eq("rst_ovf", 64'(ovf), 64'h0);
    check_eq("rst_drops", 64'(drops), 64'h0);
    check_eq("rst_done", 64'(done), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [W-1:0] hold_w;
  logic         hold_t;

  initial begin
    rst_n = 1'b0; disp = '0; mask = '1; flush = 1'b0; ready = 1'b1;
    w_rst_n = 1'b0; w_disp = '0; w_mask = '1; w_flush = 1'b0; w_ready = 1'b1;

    // Initial nonzero value records (3, 0).
    do_reset(32'h3);
    idle_cycles(6);
    check_eq("init_len", 64'(log_w.size()), 64'd2);
    check_eq("init_val", log_w[0], 64'h3);
    check_eq("init_time", log_w[1], 64'h0);
    check_eq("init_time_flag", 64'(log_t[1]), 64'h1);

    // Single change sampled at cycle 10.
    do_reset('0);
    idle_cycles(10);
    disp = 32'h5;
    idle_cycles(8);
    check_eq("single_len", 64'(log_w.size()), 64'd2);
    check_eq("single_val", log_w[0], 64'h5);
    check_eq("single_val_flag", 64'(log_t[0]), 64'h0);
    check_eq("single_time", log_w[1], 64'h10);

    // Backpressure: outputs hold while ready is low.
    ready = 1'b0;
    disp = 32'h9;
    idle_cycles(2);
    check_eq("bp_valid", 64'(valid), 64'h1);
    hold_w = word;
    hold_t = is_time;
    idle_cycles(5);
    check_eq("bp_word_stable", word, hold_w);
    check_eq("bp_flag_stable", 64'(is_time), 64'(hold_t));
    ready = 1'b1;
    idle_cycles(4);
    check_eq("bp_len", 64'(log_w.size()), 64'd4);
    check_eq("bp_val", log_w[2], 64'h9);

    // Overflow: 12 back-to-back changes into a depth-8 FIFO with no drain.
    do_reset('0);
    ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      disp = DB'(i + 1);
    end
    @(negedge clk);
    check_eq("ovf_flag", 64'(ovf), 64'h1);
    check_eq("ovf_drops", 64'(drops), 64'd4);
    ready = 1'b1;
    idle_cycles(30);
    check_eq("ovf_len", 64'(log_w.size()), 64'd16);
    for (int k = 0; k < 8; k++) check_eq("ovf_order", log_w[2*k], 64'(k + 1));

    // Randomised traffic with varying change density and sink throttling.
    do_reset($urandom);
    for (int blk = 0; blk < 6; blk++) begin
      int dens;
      dens = $urandom_range(1, 6);
      for (int c = 0; c < 250; c++) begin
        @(negedge clk);
        if ($urandom_range(0, dens) == 0) disp = $urandom;
        ready = ($urandom_range(0, 3) != 0);
`ifdef DISP_SCHED_REC_MASK_EN
        if ($urandom_range(0, 31) == 0) mask = $urandom;
`endif
      end
    end
    ready = 1'b1;
    idle_cycles(40);
    mask = '1;

    // Flush with three pending pairs; later changes are ignored.
    do_reset('0);
    ready = 1'b0;
    @(negedge clk); disp = 32'h1;
    @(negedge clk); disp = 32'h2;
    @(negedge clk); disp = 32'h3;
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0; ready = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      disp = $urandom;
      @(negedge clk);
    end
    check_eq("flush_done", 64'(done), 64'h1);
    check_eq("flush_len", 64'(log_w.size()), 64'd6);
    check_eq("flush_v1", log_w[0], 64'h1);
    check_eq("flush_v3", log_w[4], 64'h3);
    check_eq("flush_drops", 64'(drops), 64'h0);
    idle_cycles(5);
    check_eq("flush_done_hold", 64'(done), 64'h1);

    // Asynchronous reset in the middle of a pair.
    do_reset('0);
    ready = 1'b0;
    @(negedge clk); disp = 32'h7;
    idle_cycles(2);
    check_eq("mid_valid_before", 64'(valid), 64'h1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    disp = '0;
    #1;
    check_eq("mid_valid_after", 64'(valid), 64'h0);
    check_eq("mid_word_after", word, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(4);
    check_eq("mid_idle", 64'(valid), 64'h0);

    // Two-digit timestamp wraps 99 -> 00.
    @(negedge clk);
    w_rst_n = 1'b1;
    repeat (99) @(negedge clk);
    w_disp = 8'h1;
    @(negedge clk);
    w_disp = 8'h2;
    idle_cycles(8);
    check_eq("wrap_len", 64'(wlog.size()), 64'd4);
    check_eq("wrap_v0", 64'(wlog[0]), 64'h1);
    check_eq("wrap_t0", 64'(wlog[1]), 64'h99);
    check_eq("wrap_v1", 64'(wlog[2]), 64'h2);
    check_eq("wrap_t1", 64'(wlog[3]), 64'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/disp_sched_recorder.md
# disp_sched_recorder

Records a run's display-control schedule and streams it out in the ContDisps hex-file pair format.
- Watches a display-control vector on every clock.
- Timestamps each change with a BCD cycle count.
- Buffers the (value, time) pairs and serialises them as alternating value/time words over a valid/ready stream.
- Sits in the test harness as the writer for the display-control file reader; a host-side or `$fwrite` sink turns the stream into a replayable hex file.

## Interface
- DISP_BITS, 32, width of monitored display-control vector (≤ TIME_DIGS*4)
- TIME_DIGS, 16, number of BCD digits in timestamp; word width W = TIME_DIGS*4
- FIFO_DEPTH, 8, entries buffered (power of two, ≥ 2)

- Clk  in  1  clock, all state on rising edge
- nReset  in  1  reset, asynchronous, active-low
- DispIn  in  DISP_BITS  monitored display-control vector
- Flush  in  1  one-cycle pulse: finish recording after current contents drain
- WordOut  out  W  stream data: value word (zero-extended) or BCD time word
- WordValid  out  1  WordOut valid
- WordReady  in  1  sink accepts WordOut
- WordIsTime  out  1  1 = current word is the time word of a pair
- Overflow  out  1  sticky: at least one change dropped
- DropCount  out  16  changes dropped, saturating at 16'hffff
- Done  out  1  flush complete, FIFO empty

## Operation
- **Reset values:**
  - all outputs 0
  - PrevVal 0
  - BCD counter 0
  - FIFO empty
  - FSM IDLE
- **BCD counter:**
  - Increments once per cycle from the first rising edge after nReset deasserts; that edge carries count 0.
  - Per-digit carry at 9→0.
  - Wraps from all-9s to all-0s without flagging.
- **Change detect:** DispIn ≠ PrevVal at an edge → push {DispIn, count} and load PrevVal ← DispIn. PrevVal starts at 0, so a nonzero DispIn at the first edge records an entry at time 0.
- **FIFO push when full:**
  - No pop that edge → entry dropped, Overflow set, DropCount incremented.
  - Pop that same edge → push accepted.
- **Serialiser FSM, states IDLE, VAL, TIME:**
  - IDLE → VAL when FIFO not empty.
  - VAL: WordOut = value, WordIsTime 0; on WordValid&WordReady → TIME.
  - TIME: WordOut = BCD count, WordIsTime 1; on handshake → pop, then VAL if FIFO non-empty after pop, else IDLE.
- **Valid/ready rules:** WordValid = (state ≠ IDLE). WordOut and WordIsTime stay stable while WordValid & !WordReady.
- **Flush:**
  - Sets an internal flush flag; further changes are ignored (not counted as drops).
  - Done asserts once flag set and FSM IDLE with FIFO empty.
  - Done holds until reset.
- **Reset mid-operation:** asynchronously clears everything; partially sent pairs are discarded.

## Timing
- Change sampled at edge N is pushed at edge N and carries timestamp count(N).
- WordValid rises after edge N+1 when the FSM was IDLE, so first-word latency is 1 cycle after push.
- Minimum 2 cycles per pair with WordReady held high. Sustained changes faster than one per 2 cycles fill the FIFO.
- Overflow and DropCount update at the edge of the dropped push.
- Done rises the edge after the final pop, or the edge after Flush if already idle and empty.

## Configuration
- DISP_SCHED_REC_MASK_EN defined:
  - Adds input DispMask [DISP_BITS].
  - Comparison and recorded value use DispIn & DispMask; PrevVal holds the masked value.
  - A mask change alone can trigger an entry.
- Undefined: no DispMask port; all bits compared and recorded.

## Structure
- Package disp_sched_rec_pkg holds:
  - FSM state enum (IDLE, VAL, TIME)
  - BCD digit typedef
  - BCD increment function
  - DropCount width constant
- Sub-module disp_rec_fifo: synchronous FIFO, width DISP_BITS+W, depth FIFO_DEPTH, full/empty flags, simultaneous push/pop when full allowed.
- Top module holds: change detect, BCD counter, drop counter, flush logic, serialiser FSM.

## Test plan
- **Single change:** DispIn 0→32'h5 at cycle 10, WordReady=1 → words 32'h5 (WordIsTime 0) then 64'h10 (WordIsTime 1); no further words.
- **Initial nonzero:** DispIn=32'h3 from reset → first pair (3, 0).
- **Backpressure:** WordReady low 5 cycles with WordValid high → WordOut/WordIsTime stable; pair completes after WordReady rises.
- **Overflow:** FIFO_DEPTH=8, WordReady=0, DispIn toggles every cycle 12 times → 8 pairs retained in order, Overflow=1, DropCount=4.
- **BCD wrap:** TIME_DIGS=2, change at cycle 99 and cycle 100 → times 8'h99 and 8'h00.
- **Flush and reset:** 3 pending pairs + Flush → Done after third pair's time-word handshake; later changes ignored. nReset low mid-pair → all outputs 0, WordValid drops immediately.
